// File: rtl/voice_allocator.sv
// voice_allocator: assigns pressed keys to a small pool of tone-generator voices.
// One new allocation per cycle (lowest pending key first); releases are handled
// in parallel. When every voice is busy, the oldest voice is either stolen
// (STEAL=1) or the key waits for a voice to free up (STEAL=0).
module voice_allocator #(
  parameter int N_KEYS   = 5,
  parameter int N_VOICES = 2,
  parameter int STEAL    = 1,
  parameter int AGE_W    = 8,
  localparam int KW      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
  localparam int CW      = (N_VOICES > 0) ? $clog2(N_VOICES + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_KEYS-1:0]      keys,
  output logic [N_VOICES*KW-1:0] voice_note,
  output logic [N_VOICES-1:0]    voice_on,
  output logic [N_VOICES-1:0]    voice_start,
  output logic [CW-1:0]          active_cnt
);

  // The all-ones note code marks an idle voice, so no real key may use it.
  if (N_KEYS > (2 ** KW) - 1) begin : g_bad_n_keys
    $error("voice_allocator: N_KEYS=%0d collides with idle note code", N_KEYS);
  end

  localparam logic [KW-1:0]    IDLE_NOTE = {KW{1'b1}};
  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};

  logic [KW-1:0]    note_q [N_VOICES];
  logic [KW-1:0]    note_d [N_VOICES];
  logic [AGE_W-1:0] age_q  [N_VOICES];
  logic [AGE_W-1:0] age_d  [N_VOICES];
  logic [N_VOICES-1:0] on_q, on_d;
  logic [N_VOICES-1:0] start_q, start_d;
  logic [N_KEYS-1:0]   dropped_q, dropped_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [N_VOICES-1:0] held, rel, free;
  logic [N_KEYS-1:0]   assigned, pending;
  logic [KW-1:0]       pk;
  logic                pk_vld, fv_vld, alloc;
  int                  fv, sv, tv;
  logic [AGE_W-1:0]    best_age;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  // Release detection, key/voice selection and next-state computation.
  always_comb begin
    held     = '0;
    assigned = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (on_q[v] && note_q[v] == KW'(k)) begin
          assigned[k] = 1'b1;
          if (keys[k]) held[v] = 1'b1;
        end
      end
    end
    rel     = on_q & ~held;
    free    = ~on_q | rel;
    pending = keys & ~assigned & ~dropped_q;

    pk_vld = 1'b0;
    pk     = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (pending[k] && !pk_vld) begin
        pk_vld = 1'b1;
        pk     = KW'(k);
      end
    end

    fv_vld = 1'b0;
    fv     = 0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (free[v] && !fv_vld) begin
        fv_vld = 1'b1;
        fv     = v;
      end
    end

    // Oldest voice; strict compare keeps the lowest index on ties.
    sv       = 0;
    best_age = age_q[0];
    for (int v = 1; v < N_VOICES; v++) begin
      if (age_q[v] > best_age) begin
        best_age = age_q[v];
        sv       = v;
      end
    end

    dropped_d = dropped_q & keys;
    alloc     = 1'b0;
    tv        = 0;
    if (pk_vld) begin
      if (fv_vld) begin
        alloc = 1'b1;
        tv    = fv;
      end else if (STEAL != 0) begin
        alloc = 1'b1;
        tv    = sv;
        for (int k = 0; k < N_KEYS; k++) begin
          if (note_q[sv] == KW'(k)) dropped_d[k] = 1'b1;
        end
      end
    end

    on_d    = on_q & ~rel;
    start_d = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      note_d[v] = note_q[v];
      age_d[v]  = '0;
      if (on_d[v]) age_d[v] = sat_inc(age_q[v]);
      else         note_d[v] = IDLE_NOTE;
      if (alloc && tv == v) begin
        note_d[v]  = pk;
        on_d[v]    = 1'b1;
        age_d[v]   = '0;
        start_d[v] = 1'b1;
      end
    end

    cnt_d = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      cnt_d = cnt_d + CW'(on_d[v]);
    end
  end

  // State and registered outputs, synchronous reset to all-idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        note_q[v] <= IDLE_NOTE;
        age_q[v]  <= '0;
      end
      on_q      <= '0;
      start_q   <= '0;
      dropped_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        note_q[v] <= note_d[v];
        age_q[v]  <= age_d[v];
      end
      on_q      <= on_d;
      start_q   <= start_d;
      dropped_q <= dropped_d;
      cnt_q     <= cnt_d;
    end
  end

  // Flatten per-voice notes onto the output bus.
  always_comb begin
    voice_note = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      voice_note[v*KW +: KW] = note_q[v];
    end
  end

  assign voice_on    = on_q;
  assign voice_start = start_q;
  assign active_cnt  = cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a vector table for the basic flows plus
// hand-written sequences for no-steal waiting, age saturation/ties and reset.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] keys;
  logic [5:0] note_s, note_w;
  logic [1:0] on_s, on_w, st_s, st_w, cnt_s, cnt_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voice_allocator u_dut (
    .clk(clk), .rst(rst), .keys(keys),
    .voice_note(note_s), .voice_on(on_s), .voice_start(st_s), .active_cnt(cnt_s)
  );

  voice_allocator #(.STEAL(0)) u_dut_wait (
    .clk(clk), .rst(rst), .keys(keys),
    .voice_note(note_w), .voice_on(on_w), .voice_start(st_w), .active_cnt(cnt_w)
  );

  typedef struct {
    logic [4:0] keys;
    logic [5:0] note;
    logic [1:0] on;
    logic [1:0] start;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string nm, input logic [5:0] n, input logic [1:0] o,
                       input logic [1:0] s, input logic [1:0] c);
    chk({nm, ".note"},  32'(note_s), 32'(n));
    chk({nm, ".on"},    32'(on_s),   32'(o));
    chk({nm, ".start"}, 32'(st_s),   32'(s));
    chk({nm, ".cnt"},   32'(cnt_s),  32'(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{5'b00001, {3'd7, 3'd0}, 2'b01, 2'b01, 2'd1};
    vecs[1]  = '{5'b00001, {3'd7, 3'd0}, 2'b01, 2'b00, 2'd1};
    vecs[2]  = '{5'b00101, {3'd2, 3'd0}, 2'b11, 2'b10, 2'd2};
    vecs[3]  = '{5'b00100, {3'd2, 3'd7}, 2'b10, 2'b00, 2'd1};
    vecs[4]  = '{5'b00000, {3'd7, 3'd7}, 2'b00, 2'b00, 2'd0};
    vecs[5]  = '{5'b00111, {3'd7, 3'd0}, 2'b01, 2'b01, 2'd1};
    vecs[6]  = '{5'b00111, {3'd1, 3'd0}, 2'b11, 2'b10, 2'd2};
    vecs[7]  = '{5'b00111, {3'd1, 3'd2}, 2'b11, 2'b01, 2'd2};
    vecs[8]  = '{5'b00111, {3'd1, 3'd2}, 2'b11, 2'b00, 2'd2};
    vecs[9]  = '{5'b00110, {3'd1, 3'd2}, 2'b11, 2'b00, 2'd2};
    vecs[10] = '{5'b00111, {3'd0, 3'd2}, 2'b11, 2'b10, 2'd2};
    vecs[11] = '{5'b00000, {3'd7, 3'd7}, 2'b00, 2'b00, 2'd0};
    vecs[12] = '{5'b00011, {3'd7, 3'd0}, 2'b01, 2'b01, 2'd1};
    vecs[13] = '{5'b00011, {3'd1, 3'd0}, 2'b11, 2'b10, 2'd2};
    vecs[14] = '{5'b01000, {3'd7, 3'd3}, 2'b01, 2'b01, 2'd1};

    keys = '0;
    rst  = 1'b1;
    step();
    step();
    chk_s("reset", 6'h3F, 2'b00, 2'b00, 2'd0);
    rst = 1'b0;

    // Table: allocation, release, steal of oldest, dropped key, reuse on release.
    for (int i = 0; i < 15; i++) begin
      keys = vecs[i].keys;
      step();
      chk_s($sformatf("vec%0d", i), vecs[i].note, vecs[i].on, vecs[i].start, vecs[i].cnt);
    end

    // No-steal variant: third key waits, then takes the voice freed by key1.
    keys = '0;
    do_reset();
    keys = 5'b00111;
    step();
    step();
    chk("wait.t2.note", 32'(note_w), 32'({3'd1, 3'd0}));
    step();
    chk("wait.t3.note", 32'(note_w), 32'({3'd1, 3'd0}));
    chk("wait.t3.start", 32'(st_w), 32'(2'b00));
    step();
    keys = 5'b00101;
    step();
    chk("wait.take.note", 32'(note_w), 32'({3'd2, 3'd0}));
    chk("wait.take.start", 32'(st_w), 32'(2'b10));
    chk("wait.take.cnt", 32'(cnt_w), 32'(2'd2));

    // Saturated age (255) must still beat a younger voice at age 199.
    keys = '0;
    do_reset();
    keys = 5'b00001;
    step();
    repeat (99) step();
    keys = 5'b00011;
    step();
    repeat (199) step();
    keys = 5'b00111;
    step();
    chk_s("sat.steal", {3'd1, 3'd2}, 2'b11, 2'b01, 2'd2);
    // Both voices saturated: tie goes to voice 0.
    keys = 5'b00110;
    repeat (300) step();
    keys = 5'b01110;
    step();
    chk_s("sat.tie", {3'd1, 3'd3}, 2'b11, 2'b01, 2'd2);

    // Mid-operation reset with keys held: held keys re-allocate one per edge.
    keys = '0;
    do_reset();
    keys = 5'b00011;
    step();
    step();
    chk("rst.pre.on", 32'(on_s), 32'(2'b11));
    rst = 1'b1;
    step();
    chk_s("rst.mid", 6'h3F, 2'b00, 2'b00, 2'd0);
    rst = 1'b0;
    step();
    chk_s("rst.re0", {3'd7, 3'd0}, 2'b01, 2'b01, 2'd1);
    step();
    chk_s("rst.re1", {3'd1, 3'd0}, 2'b11, 2'b10, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
